// File: rtl/led_matrix_scanner_if.sv
// Frame/scan bundle between a frame generator (master) and led_matrix_scanner (slave).
// LED_SCAN_DIM_EN adds the 3-bit i_dim brightness input.
interface led_matrix_scanner_if;
    logic        i_en;
    logic        i_hold;
    logic [63:0] i_frame_g;
    logic [63:0] i_frame_r;
`ifdef LED_SCAN_DIM_EN
    logic [2:0]  i_dim;
`endif
    logic [7:0]  o_row_n;
    logic [7:0]  o_col_g_n;
    logic [7:0]  o_col_r_n;
    logic [2:0]  o_row_idx;
    logic        o_frame_done;

`ifdef LED_SCAN_DIM_EN
    modport master (
        output i_en, i_hold, i_frame_g, i_frame_r, i_dim,
        input  o_row_n, o_col_g_n, o_col_r_n, o_row_idx, o_frame_done
    );
    modport slave (
        input  i_en, i_hold, i_frame_g, i_frame_r, i_dim,
        output o_row_n, o_col_g_n, o_col_r_n, o_row_idx, o_frame_done
    );
`else
    modport master (
        output i_en, i_hold, i_frame_g, i_frame_r,
        input  o_row_n, o_col_g_n, o_col_r_n, o_row_idx, o_frame_done
    );
    modport slave (
        input  i_en, i_hold, i_frame_g, i_frame_r,
        output o_row_n, o_col_g_n, o_col_r_n, o_row_idx, o_frame_done
    );
`endif
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 bicolour LED row scanner with per-row blanking and frame-done strobe.
// Optional macro LED_SCAN_DIM_EN: gates the DRIVE phase by the i_dim brightness level.
module led_matrix_scanner #(
    parameter int unsigned DIV_COUNT    = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    led_matrix_scanner_if.slave  bus
);
    localparam int unsigned TW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV_COUNT - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;
    localparam state_t RST_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [2:0]    r_row, w_row_nxt;
    logic [63:0]   r_shadow_g, r_shadow_r;
    logic [7:0]    r_row_n, r_col_g_n, r_col_r_n;
    logic [7:0]    w_row_n_nxt, w_col_g_nxt, w_col_r_nxt;
    logic          r_frame_done;
    logic          w_last_tick, w_load_evt, w_lit;

`ifdef LED_SCAN_DIM_EN
    logic [31:0] w_on_len;
    // Only evaluated in DRIVE, where r_tick >= BLANK_CYCLES, so the subtraction cannot wrap.
    assign w_on_len = ((32'(bus.i_dim) + 32'd1) * (DIV_COUNT - BLANK_CYCLES)) / 32'd8;
    assign w_lit    = (32'(r_tick) - BLANK_CYCLES) < w_on_len;
`else
    assign w_lit = 1'b1;
`endif

    always_comb begin
        w_last_tick = (r_tick == TICK_LAST);
        w_load_evt  = bus.i_en && w_last_tick && (r_row == 3'd7);
        w_tick_nxt  = r_tick;
        w_row_nxt   = r_row;
        if (bus.i_en) begin
            if (w_last_tick) begin
                w_tick_nxt = '0;
                w_row_nxt  = r_row + 3'd1;
            end else begin
                w_tick_nxt = r_tick + TW'(1);
            end
        end
        // Phase register always tracks the phase of the tick it accompanies.
        w_state_nxt = (32'(w_tick_nxt) < BLANK_CYCLES) ? S_BLANK : S_DRIVE;

        w_row_n_nxt = '1;
        w_col_g_nxt = '1;
        w_col_r_nxt = '1;
        if (bus.i_en && (r_state == S_DRIVE) && w_lit) begin
            w_row_n_nxt = ~(8'b1 << r_row);
            w_col_g_nxt = r_shadow_g[{r_row, 3'b000} +: 8];
            w_col_r_nxt = r_shadow_r[{r_row, 3'b000} +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= RST_STATE;
            r_tick       <= '0;
            r_row        <= '0;
            r_shadow_g   <= '1;
            r_shadow_r   <= '1;
            r_row_n      <= '1;
            r_col_g_n    <= '1;
            r_col_r_n    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_row        <= w_row_nxt;
            r_row_n      <= w_row_n_nxt;
            r_col_g_n    <= w_col_g_nxt;
            r_col_r_n    <= w_col_r_nxt;
            r_frame_done <= w_load_evt;
            if (w_load_evt && !bus.i_hold) begin
                r_shadow_g <= bus.i_frame_g;
                r_shadow_r <= bus.i_frame_r;
            end
        end
    end

    assign bus.o_row_n      = r_row_n;
    assign bus.o_col_g_n    = r_col_g_n;
    assign bus.o_col_r_n    = r_col_r_n;
    assign bus.o_row_idx    = r_row;
    assign bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DIV_COUNT=8, BLANK_CYCLES=2.
// With LED_SCAN_DIM_EN defined it also exercises the dim gating.
module tb_led_matrix_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [63:0] ALL1 = '1;
    localparam logic [63:0] G1   = ~64'h1;                 // row 0 col 0 lit
    localparam logic [63:0] R5   = ~(64'hFF << 40);        // row 5 fully lit
    localparam logic [63:0] G2   = ~(64'h1 << 23);         // row 2 col 7 lit

    led_matrix_scanner_if bus ();

    led_matrix_scanner #(.DIV_COUNT(8), .BLANK_CYCLES(2)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full scan from (row 0, tick 0); sg/sr are the shadows expected on display.
    task automatic scan_check(input string tag, input logic [63:0] sg, input logic [63:0] sr,
                              input int mid_j, input logic [63:0] mid_r);
        int t, r;
        logic [7:0] e_row, e_g, e_r;
        for (int j = 1; j <= 64; j++) begin
            step();
            t = (j - 1) % 8;
            r = (j - 1) / 8;
            if (t < 2) begin
                e_row = 8'hFF; e_g = 8'hFF; e_r = 8'hFF;
            end else begin
                e_row = ~(8'b1 << r);
                e_g   = sg[8*r +: 8];
                e_r   = sr[8*r +: 8];
            end
            check($sformatf("%s.row_n r%0d t%0d", tag, r, t), 64'(bus.o_row_n), 64'(e_row));
            check($sformatf("%s.col_g r%0d t%0d", tag, r, t), 64'(bus.o_col_g_n), 64'(e_g));
            check($sformatf("%s.col_r r%0d t%0d", tag, r, t), 64'(bus.o_col_r_n), 64'(e_r));
            check($sformatf("%s.row_idx j%0d", tag, j), 64'(bus.o_row_idx), 64'((j / 8) % 8));
            check($sformatf("%s.done j%0d", tag, j), 64'(bus.o_frame_done), 64'(j == 64));
            if (j == mid_j) bus.i_frame_r = mid_r;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit;
        bus.i_en      = 1'b1;
        bus.i_hold    = 1'b0;
        bus.i_frame_g = G1;
        bus.i_frame_r = ALL1;
`ifdef LED_SCAN_DIM_EN
        bus.i_dim     = 3'd7;
`endif
        step(); step();
        check("rst.row_n", 64'(bus.o_row_n), 64'hFF);
        check("rst.col_g", 64'(bus.o_col_g_n), 64'hFF);
        check("rst.col_r", 64'(bus.o_col_r_n), 64'hFF);
        check("rst.row_idx", 64'(bus.o_row_idx), 64'd0);
        check("rst.done", 64'(bus.o_frame_done), 64'd0);
        #4 rst_n = 1'b1;

        scan_check("blank", ALL1, ALL1, 0, ALL1);
        scan_check("first", G1, ALL1, 24, R5);        // frame_r changes at row 3
        bus.i_hold = 1'b1;
        bus.i_frame_g = G2;
        scan_check("tear", G1, R5, 0, ALL1);
        bus.i_hold = 1'b0;
        scan_check("held", G1, R5, 0, ALL1);
        scan_check("new", G2, R5, 0, ALL1);

        for (int j = 0; j < 35; j++) step();          // row 4, tick 3
        check("pre_en.row_n", 64'(bus.o_row_n), 64'hEF);
        bus.i_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check("en0.row_n", 64'(bus.o_row_n), 64'hFF);
            check("en0.col_g", 64'(bus.o_col_g_n), 64'hFF);
            check("en0.col_r", 64'(bus.o_col_r_n), 64'hFF);
            check("en0.done", 64'(bus.o_frame_done), 64'd0);
            check("en0.row_idx", 64'(bus.o_row_idx), 64'd4);
        end
        bus.i_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            check("resume.row_n", 64'(bus.o_row_n), 64'hEF);
            check("resume.row_idx", 64'(bus.o_row_idx), 64'd4);
        end
        step();
        check("resume.wrap", 64'(bus.o_row_idx), 64'd5);

        for (int j = 0; j < 11; j++) step();          // row 6, tick 3
        check("pre_rst.row_n", 64'(bus.o_row_n), 64'hBF);
        #2 rst_n = 1'b0;
        #1;
        check("arst.row_n", 64'(bus.o_row_n), 64'hFF);
        check("arst.col_g", 64'(bus.o_col_g_n), 64'hFF);
        check("arst.col_r", 64'(bus.o_col_r_n), 64'hFF);
        check("arst.row_idx", 64'(bus.o_row_idx), 64'd0);
        check("arst.done", 64'(bus.o_frame_done), 64'd0);
        #1 rst_n = 1'b1;
        scan_check("post_rst", ALL1, ALL1, 0, ALL1);
        scan_check("reload", G2, R5, 0, ALL1);

`ifdef LED_SCAN_DIM_EN
        bus.i_dim = 3'd3;
        lit = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            if (bus.o_row_n != 8'hFF) lit++;
        end
        check("dim3.lit_cycles", 64'(lit), 64'd3);
`else
        lit = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Consumer end of the 8x8 frame interface driven by the food/snake generators.
- Takes full green and red frames (active-low, row-major), double-buffers them, and time-multiplexes them onto the board's 8x8 LED matrix one row at a time.
- Blanks the columns at each row change to suppress ghosting.
- Pulses a frame-done strobe once per full scan.

Parameters:
- DIV_COUNT, 1000: clk cycles per row; must be >= 4.
- BLANK_CYCLES, 16: leading cycles of each row with all columns off; must be < DIV_COUNT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  scan enable; 0 = display off, counters held
- hold  input  1  1 = freeze shadow frame (no reload at frame end)
- frame_g  input  64  green frame; bit [8*r+c] = row r, column c; 0 = lit
- frame_r  input  64  red frame; same layout and polarity
- row_n  output  8  one-hot-low row select; bit r low = row r driven
- col_g_n  output  8  green column drive, active-low
- col_r_n  output  8  red column drive, active-low
- row_idx  output  3  row currently being scanned
- frame_done  output  1  one-cycle pulse at end of row 7

Behaviour:
- Reset values (rst low, asynchronous):
  - row_n = 8'hFF; col_g_n = 8'hFF; col_r_n = 8'hFF
  - row_idx = 0; frame_done = 0
  - tick counter = 0; both shadow frames = all 1s (blank)
- Counters:
  - tick counts 0..DIV_COUNT-1 while en = 1.
  - At DIV_COUNT-1, tick wraps to 0 and row_idx increments, wrapping 7 -> 0.
- Phase (FSM, derived from tick):
  - BLANK: tick < BLANK_CYCLES.
  - DRIVE: otherwise.
- Outputs are registered and reflect the (row_idx, tick) of the previous cycle:
  - BLANK: row_n = 8'hFF; col_g_n = col_r_n = 8'hFF.
  - DRIVE: row_n = ~(1 << row_idx); col_g_n = shadow_g[row_idx]; col_r_n = shadow_r[row_idx].
- Shadow load:
  - Trigger: tick = DIV_COUNT-1 and row_idx = 7 and en = 1.
  - If hold = 0, shadow_g <= frame_g and shadow_r <= frame_r in that cycle. The new frame is first shown in row 0 of the next scan.
  - frame_done is asserted for that same cycle's registered output (one clk), regardless of hold.
- Mid-frame changes to frame_g/frame_r have no visible effect until the next shadow load, so there is no tearing.
- First scan after reset displays blank (shadow all 1s); the first real frame appears after the first frame_done.
- en = 0:
  - Next cycle: row_n, col_g_n and col_r_n are 8'hFF; frame_done = 0.
  - tick and row_idx hold their values; shadow is retained.
  - When en returns to 1, scanning resumes from the held position.
- hold = 1 across the frame end: no reload, frame_done still pulses, and the old frame keeps being displayed.
- A row and a column are never both asserted during BLANK.
- Exactly one row_n bit is low during DRIVE.
- rst asserted mid-row: all outputs go to reset values immediately (asynchronous). Scanning restarts at row 0, tick 0, with a blank shadow.

Optional Feature:
- Macro: LED_SCAN_DIM_EN.
- When defined:
  - Adds input dim, 3 bits.
  - DRIVE is further gated: columns are lit only while (tick - BLANK_CYCLES) < ((dim+1) * (DIV_COUNT-BLANK_CYCLES)) / 8. Compute this with integer truncation. Otherwise columns = 8'hFF and row_n = 8'hFF.
  - dim = 7 gives full brightness, identical to the macro-undefined behaviour.
  - dim is sampled continuously.
- When undefined: no dim port; DRIVE is lit for its full duration.

Test Plan:
- Reset release, DIV_COUNT=8, BLANK_CYCLES=2, frame_g = all 1s except bit 0 (row 0, col 0) = 0:
  - First 64 cycles: col_g_n = 8'hFF throughout.
  - frame_done pulses at cycle 64.
  - Next scan, row 0 DRIVE: row_n = 8'hFE, col_g_n = 8'hFE.
  - Other rows: col_g_n = 8'hFF.
- Row timing, same parameters, steady frame:
  - Each row shows 2 cycles with row_n = 8'hFF, then 6 cycles with row_n = ~(1 << r).
  - row_idx sequences 0..7 and wraps to 0.
- Tearing check: change frame_r mid-scan at row 3 (frame_r row 5 = 8'h00):
  - Row 5 of the current scan still shows the old data.
  - The new value appears in row 5 only after the next frame_done.
- hold = 1 across a frame boundary with a new frame_g applied:
  - frame_done still pulses.
  - Old pattern persists.
  - Releasing hold loads the new pattern at the following frame_done.
- en = 0 in the middle of row 4 for 5 cycles:
  - All outputs 8'hFF the next cycle; row_idx stays 4.
  - Scanning resumes at the same tick.
- rst low asserted during row 6 DRIVE:
  - Outputs go to 8'hFF immediately, row_idx = 0.
  - Display is blank until the next frame_done (LED_SCAN_DIM_EN build: also check dim = 3 lights 3 of 6 DRIVE cycles).
